// File: rtl/eq_ctrl_pkg.sv
// Shared types and helpers for the bit-serial equality controller.
package eq_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  // Ceiling log2, usable in constant expressions for port widths.
  function automatic int unsigned cw_of(input int unsigned w);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < w) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/eq_bit_cell.sv
// Single-bit equality cell shared across all bit positions of the serial compare.
module eq_bit_cell (
  input  logic x,
  input  logic y,
  output logic eq
);

  assign eq = (~x & ~y) | (x & y);

endmodule

// File: rtl/eq_serial_ctrl.sv
// Bit-serial equality controller: compares two WIDTH-bit operands LSB first through
// one shared equality cell and reports equality plus the lowest differing bit index.
// Optional feature macro: EQ_EARLY_EXIT_EN (finish on the first mismatching bit).
module eq_serial_ctrl
  import eq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = cw_of(WIDTH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic            busy,
  output logic            done,
  output logic            eq,
  output logic [CW-1:0]   first_diff
);

  // idx carries one extra bit so a power-of-two WIDTH never wraps before the last bit.
  localparam logic [CW:0] LastIdx = (CW + 1)'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW:0]      idx_q, idx_d;
  logic             acc_q, acc_d;
  logic             eq_q, eq_d;
  logic [CW-1:0]    fd_q, fd_d;
  logic             bit_eq;

  eq_bit_cell u_cell (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .eq (bit_eq)
  );

  // Next-state logic: accept/latch, serial scan, and result capture on entry to done.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    eq_d    = eq_q;
    fd_d    = fd_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          idx_d   = '0;
          acc_d   = 1'b1;
          fd_d    = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        // Only the first mismatch is recorded; acc drops so later ones are ignored.
        if (!bit_eq && acc_q) begin
          acc_d = 1'b0;
          fd_d  = idx_q[CW-1:0];
        end
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        idx_d = idx_q + (CW + 1)'(1);
`ifdef EQ_EARLY_EXIT_EN
        if (!bit_eq) begin
          eq_d    = 1'b0;
          state_d = StDone;
        end else if (idx_q == LastIdx) begin
          eq_d    = acc_q;
          state_d = StDone;
        end
`else
        if (idx_q == LastIdx) begin
          eq_d    = acc_q & bit_eq;
          state_d = StDone;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      idx_q   <= '0;
      acc_q   <= 1'b0;
      eq_q    <= 1'b0;
      fd_q    <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      eq_q    <= eq_d;
      fd_q    <= fd_d;
    end
  end

  // Outputs decode straight from registers; no input-to-output paths.
  always_comb begin
    busy       = (state_q == StRun);
    done       = (state_q == StDone);
    eq         = eq_q;
    first_diff = fd_q;
  end

endmodule
